// File: rtl/hc148_event_encoder.sv
// hc148_event_encoder: clocked 8-to-3 priority event encoder.
// Each active-low request line is synchronized and debounced. A debounced
// falling edge queues an event. The highest pending index is then presented
// on Dataout under a Valid/Ack handshake.
module hc148_event_encoder #(
  parameter int DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] DataIn,
  input  logic       EI,
  input  logic       Ack,
  output logic [2:0] Dataout,
  output logic       Valid,
  output logic       GS,
  output logic       EO
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    GAP     = 2'd2
  } state_t;

  localparam logic [7:0] DB_LIMIT = 8'(DEBOUNCE);

  logic [7:0] sync_meta;
  logic [7:0] sync;
  logic [7:0] filt;
  logic [7:0] filt_d;
  logic [7:0] cnt [8];
  logic [7:0] armed;
  logic [1:0] prime;
  logic [7:0] pending;
  logic [7:0] set_mask;
  logic [7:0] clr_mask;
  logic [2:0] sel;
  logic [2:0] dout_next;
  logic       valid_next;
  state_t     state;
  state_t     state_next;

  // Highest set bit of the pending vector; bit 7 wins.
  function automatic logic [2:0] top_index(input logic [7:0] v);
    top_index = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) top_index = 3'(i);
    end
  endfunction

  // Two-flop synchronizer per request line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta <= 8'hFF;
      sync      <= 8'hFF;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      sync_meta <= DataIn;
      sync      <= sync_meta;
    end
  end

  // Per-line debounce. The counter tallies consecutive synchronized samples
  // that disagree with the filtered level. Once it has seen DEBOUNCE of them,
  // the filter adopts the new level and the counter restarts. The counter is
  // capped at DEBOUNCE, so it never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt   <= 8'hFF;
      filt_d <= 8'hFF;
      // NOTE: the counter array is reset element by element. It is a small set of flops, not a RAM.
      for (int i = 0; i < 8; i++) cnt[i] <= '0;
    end else begin
      filt_d <= filt;
      for (int i = 0; i < 8; i++) begin
        if (cnt[i] == DB_LIMIT) begin
          filt[i] <= ~filt[i];
          cnt[i]  <= '0;
        end else if (sync[i] != filt[i]) begin
          cnt[i] <= cnt[i] + 8'd1;
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  // A line is armed only after it has been seen released (high) after reset.
  // A line still held low through reset release therefore cannot raise an
  // event until it rises and falls again. prime waits for the synchronizer
  // to refill before any line may arm.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prime <= 2'b00;
      armed <= 8'h00;
    end else begin
      prime <= {prime[0], 1'b1};
      armed <= armed | (sync & {8{prime[1]}});
    end
  end

  assign set_mask = filt_d & ~filt & armed & {8{~EI}};
  assign sel      = top_index(pending);

  // Pending queue. When a line is set and cleared in the same cycle, the set wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= 8'h00;
    end else begin
      pending <= (pending & ~clr_mask) | set_mask;
    end
  end

  // Handshake FSM next-state and output logic.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no latches are inferred.
    state_next = state;
    dout_next  = Dataout;
    valid_next = Valid;
    clr_mask   = 8'h00;
    case (state)
      IDLE: begin
        if (!EI && (pending != 8'h00)) begin
          dout_next  = sel;
          valid_next = 1'b1;
          state_next = PRESENT;
        end else begin
          valid_next = 1'b0;
        end
      end
      PRESENT: begin
        if (Ack) begin
          clr_mask   = 8'b1 << Dataout;
          valid_next = 1'b0;
          state_next = GAP;
        end
      end
      GAP: begin
        valid_next = 1'b0;
        state_next = IDLE;
      end
      default: begin
        valid_next = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      Dataout <= 3'd0;
      Valid   <= 1'b0;
      GS      <= 1'b1;
      EO      <= 1'b1;
    end else begin
      state   <= state_next;
      Dataout <= dout_next;
      Valid   <= valid_next;
      GS      <= EI | (pending == 8'h00);
      EO      <= EI | (pending != 8'h00);
    end
  end

endmodule
